// File: rtl/cva6_clic_irq_handshake.sv
// CLIC-to-core interrupt handshake.
// Filters the incoming CLIC interrupt against privilege, global enables and
// effective thresholds. It captures an accepted interrupt and holds a stable
// request towards the ID stage until the core commits the trap. It then returns
// a one-cycle ready pulse to the CLIC.
//
// Handshake semantics:
//   - An interrupt is taken from the CLIC only in IDLE, in the cycle where
//     clic_irq_valid_i qualifies as 'accept'.
//   - core_irq_req_o stays high, with frozen cause/shv, until core_irq_ack_i.
//   - clic_irq_ready_o pulses for exactly the cycle after the ack.
//   - A kill is acknowledged only in IDLE when nothing is being accepted in
//     that same cycle. A request already handed to the core is never withdrawn.
module cva6_clic_irq_handshake #(
   parameter int unsigned NumSrc      = 256,
   parameter int unsigned LevelW      = 8,
   parameter int unsigned XLEN        = 64,
   parameter bit          EnableUMode = 1'b0,
   parameter int unsigned CntW        = 16,
   localparam int unsigned IdW        = $clog2(NumSrc)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [1:0]        priv_lvl_i,
   input  logic              mie_i,
   input  logic              sie_i,
   input  logic              uie_i,
   input  logic [LevelW-1:0] mintthresh_i,
   input  logic [LevelW-1:0] sintthresh_i,
   input  logic [LevelW-1:0] uintthresh_i,
   input  logic [LevelW-1:0] mil_i,
   input  logic [LevelW-1:0] sil_i,
   input  logic [LevelW-1:0] uil_i,
   input  logic              clic_irq_valid_i,
   input  logic [IdW-1:0]    clic_irq_id_i,
   input  logic [LevelW-1:0] clic_irq_level_i,
   input  logic [1:0]        clic_irq_priv_i,
   input  logic              clic_irq_shv_i,
   output logic              clic_irq_ready_o,
   input  logic              clic_kill_req_i,
   output logic              clic_kill_ack_o,
   output logic              core_irq_req_o,
   output logic [XLEN-1:0]   core_irq_cause_o,
   output logic              core_irq_shv_o,
   input  logic              core_irq_ack_i,
   input  logic              cnt_clear_i,
   output logic [CntW-1:0]   cnt_taken_o,
   output logic [CntW-1:0]   cnt_kill_o
);

   localparam logic [1:0] PrivU = 2'b00;
   localparam logic [1:0] PrivS = 2'b01;
   localparam logic [1:0] PrivM = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic              accept;
   logic [LevelW-1:0] thr_m, thr_s, thr_u;
   logic              cap_vld_q;
   logic [IdW-1:0]    id_q;
   logic [LevelW-1:0] level_q;
   logic              shv_q;
   logic [CntW-1:0]   cnt_taken_q, cnt_kill_q;

   // Effective thresholds: the larger of the programmed threshold and the current level
   assign thr_m = (mintthresh_i > mil_i) ? mintthresh_i : mil_i;
   assign thr_s = (sintthresh_i > sil_i) ? sintthresh_i : sil_i;
   assign thr_u = (uintthresh_i > uil_i) ? uintthresh_i : uil_i;

   // Accept filter: higher-privilege targets preempt, same privilege needs level and enable
   always_comb begin
      accept = 1'b0;
      if (clic_irq_valid_i) begin
         case (priv_lvl_i)
            PrivM: begin
               accept = (clic_irq_priv_i == PrivM) && (clic_irq_level_i > thr_m) && mie_i;
            end
            PrivS: begin
               if (clic_irq_priv_i == PrivM) begin
                  accept = 1'b1;
               end else if (clic_irq_priv_i == PrivS) begin
                  accept = (clic_irq_level_i > thr_s) && sie_i;
               end
            end
            PrivU: begin
               if ((clic_irq_priv_i == PrivM) || (clic_irq_priv_i == PrivS)) begin
                  accept = 1'b1;
               end else if (clic_irq_priv_i == PrivU) begin
                  accept = EnableUMode && (clic_irq_level_i > thr_u) && uie_i;
               end
            end
            default: accept = 1'b0;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: IDLE -> REQ on accept, REQ -> ACK on core ack, ACK -> IDLE always
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ;
         REQ:     if (core_irq_ack_i) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: request held through REQ, ready pulse in ACK, kill resolved only when idle
   always_comb begin
      core_irq_req_o   = (state_q == REQ);
      clic_irq_ready_o = (state_q == ACK);
      clic_kill_ack_o  = clic_kill_req_i && (state_q == IDLE) && !accept;
   end

   // Capture registers: loaded on accept in IDLE, frozen otherwise
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cap_vld_q <= 1'b0;
         id_q      <= '0;
         level_q   <= '0;
         shv_q     <= 1'b0;
      end else if ((state_q == IDLE) && accept) begin
         cap_vld_q <= 1'b1;
         id_q      <= clic_irq_id_i;
         level_q   <= clic_irq_level_i;
         shv_q     <= clic_irq_shv_i;
      end
   end

   // Cause packing: interrupt flag in the MSB, level at bit 16, id at the bottom
   always_comb begin
      core_irq_cause_o                = '0;
      core_irq_cause_o[XLEN-1]        = cap_vld_q;
      core_irq_cause_o[16 +: LevelW]  = level_q;
      core_irq_cause_o[IdW-1:0]       = id_q;
      core_irq_shv_o                  = shv_q;
   end

   // Saturating event counters; clear takes priority over increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_taken_q <= '0;
         cnt_kill_q  <= '0;
      end else if (cnt_clear_i) begin
         cnt_taken_q <= '0;
         cnt_kill_q  <= '0;
      end else begin
         if ((state_q == ACK) && (cnt_taken_q != '1)) cnt_taken_q <= cnt_taken_q + 1'b1;
         if (clic_kill_ack_o && (cnt_kill_q != '1))   cnt_kill_q  <= cnt_kill_q + 1'b1;
      end
   end

   assign cnt_taken_o = cnt_taken_q;
   assign cnt_kill_o  = cnt_kill_q;

endmodule
